// File: rtl/fetch_pc_sequencer_if.sv
// Fetch PC sequencer bus: hazard/branch
// inputs and the fetch address outputs.
interface fetch_pc_sequencer_if #(
  parameter int ADDR_W = 64
);
  logic              stall;
  logic              br_taken;
  logic [ADDR_W-1:0] br_pc;
  logic [ADDR_W-1:0] br_imm;
  logic              br_reg;
  logic [ADDR_W-1:0] br_reg_target;
  logic [ADDR_W-1:0] pc;
  logic              flush;
  logic              busy;

  modport master (
    output stall, br_taken, br_pc,
    output br_imm, br_reg, br_reg_target,
    input  pc, flush, busy
  );

  modport slave (
    input  stall, br_taken, br_pc,
    input  br_imm, br_reg, br_reg_target,
    output pc, flush, busy
  );
endinterface

// File: rtl/fetch_pc_sequencer.sv
// Fetch PC owner: sequential fetch, redirects,
// stall parking and counted wrong-path flush.
module fetch_pc_sequencer #(
  parameter int              ADDR_W       = 64,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int              FLUSH_CYCLES = 2
) (
  input logic clk,
  input logic reset_n,
  fetch_pc_sequencer_if.slave bus
);
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HOLD  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [2:0] FC = 3'(FLUSH_CYCLES);
  localparam state_t AFTER = (FLUSH_CYCLES == 0)
                             ? RUN : FLUSH;

  state_t            state, stateN;
  logic [ADDR_W-1:0] pc, pcN;
  logic [ADDR_W-1:0] holdTgt, holdTgtN;
  logic [2:0]        cnt, cntN;
  logic [ADDR_W-1:0] target;
  logic              redirect;

  assign target = bus.br_taken
    ? bus.br_pc + (bus.br_imm << 2)
    : bus.br_reg_target & ~ADDR_W'(3);

  assign redirect = (bus.br_taken | bus.br_reg)
                    & (state == RUN);

  always_comb begin
    stateN   = state;
    pcN      = pc;
    holdTgtN = holdTgt;
    cntN     = cnt;
    unique case (state)
      RUN: begin
        if (redirect && bus.stall) begin
          holdTgtN = target;
          stateN   = HOLD;
        end else if (redirect) begin
          pcN    = target;
          cntN   = FC;
          stateN = AFTER;
        end else if (!bus.stall) begin
          pcN = pc + ADDR_W'(4);
        end
      end
      HOLD: begin
        if (!bus.stall) begin
          pcN    = holdTgt;
          cntN   = FC;
          stateN = AFTER;
        end
      end
      FLUSH: begin
        if (!bus.stall) begin
          pcN  = pc + ADDR_W'(4);
          cntN = cnt - 3'd1;
          if (cnt == 3'd1) stateN = RUN;
        end
      end
      default: stateN = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= RUN;
      pc      <= RESET_PC;
      holdTgt <= '0;
      cnt     <= '0;
    end else begin
      state   <= stateN;
      pc      <= pcN;
      holdTgt <= holdTgtN;
      cnt     <= cntN;
    end
  end

  assign bus.pc    = pc;
  assign bus.flush = (state == FLUSH);
  assign bus.busy  = (state != RUN);
endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// Directed plus randomized checks of the fetch
// PC sequencer against a behavioural model.
module tb_fetch_pc_sequencer;
  localparam int FC = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  logic [63:0] mPc;
  logic [63:0] mTgt;
  bit          mPend;
  int          mFl;

  always #5 clk = ~clk;

  fetch_pc_sequencer_if #(.ADDR_W(64)) bus ();

  fetch_pc_sequencer #(
    .ADDR_W(64),
    .RESET_PC(64'h0),
    .FLUSH_CYCLES(FC)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  task automatic chk(string tag,
                     logic [63:0] obs,
                     logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic mReset();
    mPc   = 64'h0;
    mTgt  = 64'h0;
    mPend = 0;
    mFl   = 0;
  endtask

  function automatic logic [63:0] calcTgt();
    if (bus.br_taken)
      return bus.br_pc + bus.br_imm * 64'd4;
    return bus.br_reg_target & ~64'd3;
  endfunction

  task automatic mStep();
    bit idle;
    idle = !mPend && mFl == 0;
    if (idle && (bus.br_taken || bus.br_reg)) begin
      if (bus.stall) begin
        mPend = 1;
        mTgt  = calcTgt();
      end else begin
        mPc = calcTgt();
        mFl = FC;
      end
    end else if (mPend) begin
      if (!bus.stall) begin
        mPc   = mTgt;
        mPend = 0;
        mFl   = FC;
      end
    end else if (!bus.stall) begin
      mPc = mPc + 64'd4;
      if (mFl > 0) mFl--;
    end
  endtask

  task automatic chkAll(string tag);
    chk({tag, ".pc"}, bus.pc, mPc);
    chk({tag, ".flush"}, 64'(bus.flush),
        64'(!mPend && mFl > 0));
    chk({tag, ".busy"}, 64'(bus.busy),
        64'(mPend || mFl > 0));
  endtask

  task automatic step(string tag);
    mStep();
    @(posedge clk);
    #1;
    chkAll(tag);
  endtask

  task automatic idle();
    bus.stall         = 1'b0;
    bus.br_taken      = 1'b0;
    bus.br_reg        = 1'b0;
    bus.br_pc         = 64'h0;
    bus.br_imm        = 64'h0;
    bus.br_reg_target = 64'h0;
  endtask

  task automatic brT(logic [63:0] p,
                     logic [63:0] imm);
    bus.br_taken = 1'b1;
    bus.br_pc    = p;
    bus.br_imm   = imm;
  endtask

  initial begin
    idle();
    mReset();
    #1;
    chkAll("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // 1: sequential fetch
    for (int i = 0; i < 3; i++) step("seq");
    chk("seq.pc12", bus.pc, 64'd12);

    // 2: taken branch, full flush window
    brT(64'h100, 64'h10);
    step("br");
    chk("br.pc", bus.pc, 64'h140);
    chk("br.flush", 64'(bus.flush), 64'd1);
    idle();
    step("br1");
    chk("br1.pc", bus.pc, 64'h144);
    step("br2");
    chk("br2.pc", bus.pc, 64'h148);
    chk("br2.busy", 64'(bus.busy), 64'd0);

    // 3: redirect parked under stall
    brT(64'h100, '1);
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) step("hold");
    chk("hold.busy", 64'(bus.busy), 64'd1);
    idle();
    step("rel");
    chk("rel.pc", bus.pc, 64'hFC);
    step("rel1");
    step("rel2");

    // 4: register target and priority
    bus.br_reg        = 1'b1;
    bus.br_reg_target = 64'h2003;
    step("reg");
    chk("reg.pc", bus.pc, 64'h2000);
    idle();
    step("reg1");
    step("reg2");
    bus.br_reg        = 1'b1;
    bus.br_reg_target = 64'h9000;
    brT(64'h40, 64'h1);
    step("pri");
    chk("pri.pc", bus.pc, 64'h44);

    // 5: ignored redirect and stall in flush
    idle();
    brT(64'h800, 64'h8);
    step("ign");
    chk("ign.pc", bus.pc, 64'h48);
    idle();
    bus.stall = 1'b1;
    step("fst0");
    step("fst1");
    bus.stall = 1'b0;
    step("fst2");
    chk("fst2.flush", 64'(bus.flush), 64'd0);

    // 6: async reset mid-hold, then wrap
    brT(64'h500, 64'h4);
    bus.stall = 1'b1;
    step("h6");
    #2;
    reset_n = 1'b0;
    mReset();
    #1;
    chkAll("arst");
    chk("arst.busy", 64'(bus.busy), 64'd0);
    idle();
    @(negedge clk);
    reset_n = 1'b1;
    bus.br_reg        = 1'b1;
    bus.br_reg_target = 64'hFFFF_FFFF_FFFF_FFFC;
    step("wr0");
    idle();
    step("wrap");
    chk("wrap.pc", bus.pc, 64'h0);
    step("wr2");
    step("wr3");

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      bus.stall    = ($urandom_range(3) == 0);
      bus.br_taken = ($urandom_range(5) == 0);
      bus.br_reg   = ($urandom_range(5) == 0);
      bus.br_pc    = {$urandom, $urandom};
      bus.br_imm   = ($urandom_range(1) == 0)
                     ? 64'($signed($urandom_range(255)) - 128)
                     : {$urandom, $urandom};
      bus.br_reg_target = {$urandom, $urandom};
      step("rnd");
    end

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end
endmodule
